// File: rtl/frog_pkg.sv
// Shared definitions for the frog game datapath: FSM encodings, field widths
// and the period floor used by both the scheduler and the car instances.
package frog_pkg;

   localparam int LEVEL_W        = 7;
   localparam int PERIOD_W       = 8;
   localparam int MIN_PERIOD_DEF = 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_PAUSE = 2'd3;

   function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] level,
                                                      input logic [LEVEL_W-1:0] max_level);
      return (level > max_level) ? max_level : level;
   endfunction

endpackage

// File: rtl/traffic_scheduler_lane_timer.sv
// Per-lane step timer: counts movement ticks down from period-1 and strobes
// for one cycle when it reaches zero, then reloads.
module lane_timer
   import frog_pkg::*;
(
   input  logic                i_Clk,
   input  logic                i_Rst,
   input  logic                load,
   input  logic [PERIOD_W-1:0] period,
   input  logic                tick,
   input  logic                hold,
   output logic                step
);

   logic [PERIOD_W-1:0] period_q;
   logic [PERIOD_W-1:0] cnt;

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         period_q <= '0;
         cnt      <= '0;
         step     <= 1'b0;
      end else begin
         step <= 1'b0;
         if (load) begin
            period_q <= period;
            cnt      <= period - PERIOD_W'(1);
         end else if (tick && !hold) begin
            if (cnt == '0) begin
               step <= 1'b1;
               cnt  <= period_q - PERIOD_W'(1);
            end else begin
               cnt <= cnt - PERIOD_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/traffic_scheduler.sv
// Central lane step scheduler: shared movement-tick prescaler, level-driven
// period calculation and start/pause/reload sequencing for all lane timers.
module traffic_scheduler
   import frog_pkg::*;
#(
   parameter int NUM_LANES   = 4,
   parameter int CLK_DIV     = 250000,
   parameter int BASE_PERIOD = 20,
   parameter int LANE_SPREAD = 4,
   parameter int LEVEL_STEP  = 2,
   parameter int MIN_PERIOD  = MIN_PERIOD_DEF,
   parameter int MAX_LEVEL   = 99
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst,
   input  logic                 i_start,
   input  logic                 i_pause,
   input  logic                 i_level_load,
   input  logic [LEVEL_W-1:0]   i_level,
   output logic [NUM_LANES-1:0] o_lane_step,
   output logic                 o_running,
   output logic                 o_busy
);

   localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic signed [11:0] MIN_S = 12'(MIN_PERIOD);
   localparam logic signed [11:0] MAX_S = 12'sd255;

   logic [1:0]           state;
   logic [1:0]           state_next;
   logic [PRE_W-1:0]     presc;
   logic [IDX_W-1:0]     load_idx;
   logic [LEVEL_W-1:0]   lvl;
   logic                 tick;
   logic                 load_last;
   logic                 level_capture;
   logic signed [11:0]   base_term;
   logic signed [11:0]   lane_term;
   logic signed [11:0]   level_term;
   logic signed [11:0]   raw_period;
   logic [PERIOD_W-1:0]  calc_period;

   assign tick          = (state == ST_RUN) && (presc == PRE_W'(CLK_DIV - 1));
   assign load_last     = (load_idx == IDX_W'(NUM_LANES - 1));
   assign level_capture = (state_next == ST_LOAD) && (state != ST_LOAD);

   // A level reload outranks both pause and unpause so lanes always realign.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (i_start) state_next = ST_LOAD;
         ST_LOAD:  if (load_last) state_next = ST_RUN;
         ST_RUN: begin
            if (i_level_load)  state_next = ST_LOAD;
            else if (i_pause)  state_next = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (i_level_load)  state_next = ST_LOAD;
            else if (!i_pause) state_next = ST_RUN;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state     <= ST_IDLE;
         presc     <= '0;
         load_idx  <= '0;
         lvl       <= '0;
         o_running <= 1'b0;
         o_busy    <= 1'b0;
      end else begin
         state     <= state_next;
         o_running <= (state_next == ST_RUN);
         o_busy    <= (state_next == ST_LOAD);
         if (level_capture) begin
            lvl      <= clamp_level(i_level, LEVEL_W'(MAX_LEVEL));
            load_idx <= '0;
         end else if (state == ST_LOAD) begin
            load_idx <= load_idx + IDX_W'(1);
         end
         if (state == ST_LOAD) begin
            presc <= '0;
         end else if (state == ST_RUN) begin
            presc <= tick ? '0 : presc + PRE_W'(1);
         end
      end
   end

   // One calculator shared by all lanes; LOAD walks load_idx across them.
   always_comb begin
      base_term   = 12'(BASE_PERIOD);
      lane_term   = 12'(load_idx) * 12'(LANE_SPREAD);
      level_term  = 12'(lvl) * 12'(LEVEL_STEP);
      raw_period  = base_term + lane_term - level_term;
      calc_period = raw_period[PERIOD_W-1:0];
      if (raw_period < MIN_S) begin
         calc_period = PERIOD_W'(MIN_PERIOD);
      end else if (raw_period > MAX_S) begin
         calc_period = '1;
      end
   end

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      lane_timer u_lane_timer (
         .i_Clk  (i_Clk),
         .i_Rst  (i_Rst),
         .load   ((state == ST_LOAD) && (load_idx == IDX_W'(k))),
         .period (calc_period),
         .tick   (tick),
         .hold   (state != ST_RUN),
         .step   (o_lane_step[k])
      );
   end

endmodule
